// File: rtl/cic_pkg.sv
// Shared constants and the gain-normalisation helper for the CIC interpolator.
package cic_pkg;

  localparam int unsigned CIC_N              = 4;
  localparam int unsigned CIC_MAX_LOG2_RATE  = 7;
  localparam int unsigned CIC_BW             = 16;
  localparam int unsigned CIC_MAXBITGAIN     = (CIC_N - 1) * CIC_MAX_LOG2_RATE;
  localparam int unsigned CIC_W              = CIC_BW + CIC_MAXBITGAIN;

  // Smallest s with 2**s >= rate**3, i.e. ceil(3*log2(rate)); rate 0 acts as 1.
  // Clamped to the largest gain the internal width can absorb.
  function automatic logic [4:0] bitgain_interp(input logic [7:0] rate);
    logic [31:0] r;
    logic [31:0] cube;
    logic [4:0]  g;
    r    = (rate == 8'd0) ? 32'd1 : {24'd0, rate};
    cube = r * r * r;
    g    = 5'(CIC_MAXBITGAIN);
    for (int unsigned i = 0; i <= CIC_MAXBITGAIN; i++) begin
      if ((32'd1 << (CIC_MAXBITGAIN - i)) >= cube) begin
        g = 5'(CIC_MAXBITGAIN - i);
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/cic_int_shifter.sv
// Output stage of the CIC interpolator: registered gain shift and output slice.
// Build option CIC_INTERP_ROUND_EN: round half-up before the slice and saturate
// to the bw-bit range; otherwise plain floor truncation, no saturation.
module cic_int_shifter
  import cic_pkg::*;
#(
  parameter int unsigned bw = CIC_BW,
  parameter int unsigned W  = CIC_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [7:0]          rate,
  input  logic                strobe_out,
  input  logic signed [W-1:0] integ_in,
  output logic [bw-1:0]       signal_out
);

  logic [4:0]    shift_q;
  logic          strobe_q;
  logic [bw-1:0] out_q;
  logic [bw-1:0] out_d;

`ifdef CIC_INTERP_ROUND_EN
  localparam logic signed [W:0] SAT_MAX = {{(W-bw+2){1'b0}}, {(bw-1){1'b1}}};
  localparam logic signed [W:0] SAT_MIN = {{(W-bw+2){1'b1}}, {(bw-1){1'b0}}};
  logic signed [W:0] ext;
  logic signed [W:0] bias;
  logic signed [W:0] rounded;
  logic signed [W:0] shifted;

  // Round half-up in one extra bit of headroom, shift, then clamp.
  always_comb begin
    ext  = {integ_in[W-1], integ_in};
    bias = '0;
    if (shift_q != 5'd0) begin
      bias[shift_q - 5'd1] = 1'b1;
    end
    rounded = ext + bias;
    shifted = rounded >>> shift_q;
    if (shifted > SAT_MAX) begin
      out_d = SAT_MAX[bw-1:0];
    end else if (shifted < SAT_MIN) begin
      out_d = SAT_MIN[bw-1:0];
    end else begin
      out_d = bw'(shifted);
    end
  end
`else
  // Floor truncation: bits [bw-1+shift : shift] of the last integrator.
  always_comb begin
    out_d = bw'(integ_in >>> shift_q);
  end
`endif

  // Shift amount tracks rate every cycle (one cycle lag).
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q <= '0;
    end else begin
      shift_q <= bitgain_interp(rate);
    end
  end

  // Output sample is taken the cycle after strobe_out, once the integrators have moved.
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      strobe_q <= 1'b0;
      out_q    <= '0;
    end else begin
      strobe_q <= strobe_out;
      if (strobe_q) begin
        out_q <= out_d;
      end
    end
  end

  assign signal_out = out_q;

endmodule

// File: rtl/cic_int_shifter_interp.sv
// 4-stage CIC interpolator (differential delay 1) with gain normalisation.
// Combs step on strobe_in, integrators on strobe_out, zero-stuffed in between.
// Build option CIC_INTERP_ROUND_EN selects rounding+saturation in the output stage.
module cic_int_shifter_interp
  import cic_pkg::*;
#(
  parameter int unsigned bw        = CIC_BW,
  parameter int unsigned N         = CIC_N,
  parameter int unsigned log2_rate = CIC_MAX_LOG2_RATE
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic [7:0]    rate,
  input  logic          strobe_in,
  input  logic          strobe_out,
  input  logic [bw-1:0] signal_in,
  output logic [bw-1:0] signal_out,
  output logic          overrun
);

  localparam int unsigned maxbitgain = (N - 1) * log2_rate;
  localparam int unsigned W          = bw + maxbitgain;

  logic signed [W-1:0] sample_q, sample_d;
  logic signed [W-1:0] comb_q  [N];
  logic signed [W-1:0] comb_d  [N];
  logic signed [W-1:0] dly_q   [N];
  logic signed [W-1:0] dly_d   [N];
  logic signed [W-1:0] integ_q [N];
  logic signed [W-1:0] integ_d [N];
  logic                pending_q, pending_d;
  logic                overrun_q, overrun_d;

  // Comb chain: one stage advance per input strobe, full-width sign-extended arithmetic.
  always_comb begin
    sample_d = sample_q;
    comb_d   = comb_q;
    dly_d    = dly_q;
    if (strobe_in) begin
      sample_d  = {{maxbitgain{signal_in[bw-1]}}, signal_in};
      comb_d[0] = sample_q - dly_q[0];
      dly_d[0]  = sample_q;
      for (int unsigned k = 1; k < N; k++) begin
        comb_d[k] = comb_q[k-1] - dly_q[k];
        dly_d[k]  = comb_q[k-1];
      end
    end
  end

  // Integrator chain with zero stuffing; wrap-around is intentional (CIC modular property).
  // A coincident strobe_in leaves pending set: the output strobe eats the old comb value.
  always_comb begin
    integ_d   = integ_q;
    pending_d = pending_q;
    overrun_d = overrun_q | (strobe_in & pending_q & ~strobe_out);
    if (strobe_out) begin
      integ_d[0] = integ_q[0] + (pending_q ? comb_q[N-1] : '0);
      for (int unsigned k = 1; k < N; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
      pending_d = 1'b0;
    end
    if (strobe_in) begin
      pending_d = 1'b1;
    end
  end

  // Datapath state register; cleared by reset or while disabled.
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      sample_q  <= '0;
      comb_q    <= '{default: '0};
      dly_q     <= '{default: '0};
      integ_q   <= '{default: '0};
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sample_q  <= sample_d;
      comb_q    <= comb_d;
      dly_q     <= dly_d;
      integ_q   <= integ_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  cic_int_shifter #(
    .bw (bw),
    .W  (W)
  ) u_shifter (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .rate       (rate),
    .strobe_out (strobe_out),
    .integ_in   (integ_q[N-1]),
    .signal_out (signal_out)
  );

  assign overrun = overrun_q;

endmodule

// File: tb/tb_cic_int_shifter_interp.sv
// Bench for cic_int_shifter_interp: random and directed strobe patterns checked
// against a transaction-level CIC model (binomial 4th difference + prefix sums).
module tb_cic_int_shifter_interp;

  localparam longint MASK = (longint'(1) << 37) - 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  rate = 8'd1;
  logic        strobe_in = 1'b0;
  logic        strobe_out = 1'b0;
  logic [15:0] signal_in = '0;
  logic [15:0] signal_out;
  logic        overrun;

  always #5 clock = ~clock;

  cic_int_shifter_interp dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .rate       (rate),
    .strobe_in  (strobe_in),
    .strobe_out (strobe_out),
    .signal_in  (signal_in),
    .signal_out (signal_out),
    .overrun    (overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state
  longint hist[$];
  bit     m_pend, m_ovr, m_so_d;
  longint y[4];
  longint exp_out;
  bit     rec;
  longint recq[$];

  function automatic longint xval(int k);
    if (k < 1 || k > hist.size()) return 0;
    return hist[k-1];
  endfunction

  // Fourth difference of the accepted input samples, delayed by the comb pipeline.
  function automatic longint comb_out();
    int m;
    m = hist.size();
    return xval(m-4) - 4*xval(m-5) + 6*xval(m-6) - 4*xval(m-7) + xval(m-8);
  endfunction

  function automatic longint to_signed37(longint v);
    longint t;
    t = v & MASK;
    if (t >= (longint'(1) << 36)) t = t - (longint'(1) << 37);
    return t;
  endfunction

  function automatic int model_shift(int r);
    int rr;
    rr = (r == 0) ? 1 : r;
    return $clog2(rr * rr * rr);
  endfunction

  function automatic longint model_out(longint acc, int sh);
    longint s;
    s = to_signed37(acc);
`ifdef CIC_INTERP_ROUND_EN
    if (sh > 0) s = s + (longint'(1) << (sh - 1));
    s = s >>> sh;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
`else
    s = (s >>> sh) & 64'hFFFF;
    if (s >= 32768) s = s - 65536;
    return s;
`endif
  endfunction

  task automatic tick(input bit si, input bit so, input logic [15:0] x);
    longint u;
    longint n0, n1, n2, n3;
    strobe_in  = si;
    strobe_out = so;
    signal_in  = x;
    @(posedge clock);
    if (reset || !enable) begin
      hist.delete();
      m_pend = 0; m_ovr = 0; m_so_d = 0;
      y = '{default: 0};
      exp_out = 0;
    end else begin
      if (m_so_d) exp_out = model_out(y[3], model_shift(int'(rate)));
      m_so_d = so;
      if (so) begin
        u  = m_pend ? comb_out() : 0;
        n0 = (y[0] + u) & MASK;
        n1 = (y[1] + y[0]) & MASK;
        n2 = (y[2] + y[1]) & MASK;
        n3 = (y[3] + y[2]) & MASK;
        y[0] = n0; y[1] = n1; y[2] = n2; y[3] = n3;
      end
      if (si) begin
        if (m_pend && !so) m_ovr = 1;
        hist.push_back(longint'($signed(x)));
      end
      if (so) m_pend = 0;
      if (si) m_pend = 1;
    end
    #1;
    check_eq("signal_out", longint'($signed(signal_out)), exp_out);
    check_eq("overrun", longint'(overrun), longint'(m_ovr));
    if (rec) recq.push_back(longint'($signed(signal_out)));
    strobe_in  = 1'b0;
    strobe_out = 1'b0;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) tick(0, 0, 16'h0);
    reset = 1'b0;
  endtask

  task automatic run_dc(input int r, input logic [15:0] dc, input int nin, input bit gaps);
    for (int i = 0; i < nin; i++) begin
      for (int j = 0; j < r; j++) begin
        tick(j == 0, 1'b1, dc);
        if (gaps && ($urandom_range(0, 1) == 1)) tick(0, 0, dc);
      end
    end
  endtask

  initial begin
    longint fresh[$];
    int     rates[8] = '{1, 2, 3, 5, 7, 16, 100, 128};
    int     r;

    // 1: rate 1, DC 1000
    rate = 8'd1;
    do_reset();
    check_eq("rst_out", longint'($signed(signal_out)), 0);
    check_eq("rst_ovr", longint'(overrun), 0);
    run_dc(1, 16'd1000, 20, 1'b0);
    check_eq("t1_dc", longint'($signed(signal_out)), 1000);
    check_eq("t1_ovr", longint'(overrun), 0);

    // 2: rate 8, unity gain, with idle gaps between output strobes
    rate = 8'd8;
    do_reset();
    run_dc(8, 16'd1000, 20, 1'b1);
    check_eq("t2_dc", longint'($signed(signal_out)), 1000);

    // 3: rate 5, gain 125/128
    rate = 8'd5;
    do_reset();
    run_dc(5, 16'd12800, 24, 1'b0);
    check_eq("t3_dc", longint'($signed(signal_out)), 12500);

    // 4: rate 128, full-scale negative then positive
    rate = 8'd128;
    do_reset();
    run_dc(128, 16'h8000, 16, 1'b0);
    check_eq("t4_neg", longint'($signed(signal_out)), -32768);
    run_dc(128, 16'h7FFF, 16, 1'b0);
    check_eq("t4_pos", longint'($signed(signal_out)), 32767);

    // 5: overrun is sticky until enable drops
    rate = 8'd4;
    do_reset();
    run_dc(4, 16'd100, 3, 1'b0);
    check_eq("t5_pre", longint'(overrun), 0);
    tick(1, 0, 16'd200);
    tick(1, 0, 16'd300);
    check_eq("t5_set", longint'(overrun), 1);
    repeat (3) tick(0, 1, 16'd0);
    check_eq("t5_hold", longint'(overrun), 1);
    enable = 1'b0;
    tick(0, 0, 16'd0);
    check_eq("t5_clr", longint'(overrun), 0);
    enable = 1'b1;

    // 6: clear mid-stream reproduces a fresh run (enable-low and reset variants)
    rate = 8'd16;
    do_reset();
    recq.delete(); rec = 1;
    run_dc(16, 16'd500, 12, 1'b0);
    rec = 0;
    fresh = recq;
    check_eq("t6_dc", longint'($signed(signal_out)), 500);
    run_dc(16, 16'd500, 5, 1'b0);
    enable = 1'b0;
    tick(0, 0, 16'd0);
    check_eq("t6_en_clr", longint'($signed(signal_out)), 0);
    enable = 1'b1;
    recq.delete(); rec = 1;
    run_dc(16, 16'd500, 12, 1'b0);
    rec = 0;
    check_eq("t6_en_len", recq.size(), fresh.size());
    for (int i = 0; i < fresh.size() && i < recq.size(); i++)
      check_eq("t6_en_seq", recq[i], fresh[i]);
    run_dc(16, 16'd500, 5, 1'b0);
    reset = 1'b1;
    tick(0, 0, 16'd0);
    check_eq("t6_rst_clr", longint'($signed(signal_out)), 0);
    reset = 1'b0;
    recq.delete(); rec = 1;
    run_dc(16, 16'd500, 12, 1'b0);
    rec = 0;
    check_eq("t6_rst_len", recq.size(), fresh.size());
    for (int i = 0; i < fresh.size() && i < recq.size(); i++)
      check_eq("t6_rst_seq", recq[i], fresh[i]);

    // 7: random data and strobes, occasional enable drop
    for (int t = 0; t < 8; t++) begin
      r = rates[$urandom_range(0, 7)];
      rate = 8'(r);
      do_reset();
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, 199) == 0) enable = 1'b0;
        else enable = 1'b1;
        tick($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, 16'($urandom));
      end
      enable = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net against a stuck simulation
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
